pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 The module SHALL have parameter CNT_W, default 32, meaning the width of each performance counter.
REQ-003 The module SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 The module SHALL have port PC_FS, input, 2, the PC function select: 00 hold, 01 plus4, 10 load-in, 11 jump.
REQ-006 The module SHALL have port k, input, 64, the sign-extended branch offset in instruction words.
REQ-007 The module SHALL have port in, input, 64, the register-sourced branch target (BR path).
REQ-008 The module SHALL have port status_in, input, 4, the {V,C,N,Z} flags from the ALU.
REQ-009 The module SHALL have port status_load, input, 1, which latches status_in.
REQ-010 The module SHALL have port PC, output, 64, the current program counter.
REQ-011 The module SHALL have port PC4, output, 64, combinational PC+4, used as the link value.
REQ-012 The module SHALL have port status, output, 4, the registered {V,C,N,Z} flags.
REQ-013 The module SHALL have port align_fault, output, 1, a sticky flag set by a misaligned load-in target.
REQ-014 The module SHALL have port instr_cnt, output, CNT_W, counting PC advances.
REQ-015 The module SHALL have port taken_cnt, output, CNT_W, counting taken branches.

Function
REQ-016 PC_FS=00 SHALL hold PC unchanged in the next cycle.
REQ-017 PC_FS=01 SHALL set PC to PC+4 in the next cycle.
REQ-018 PC_FS=10 SHALL set PC to {in[63:2],2'b00} in the next cycle.
REQ-019 PC_FS=11 SHALL set PC to PC+(k<<2) in the next cycle.
REQ-020 All PC arithmetic SHALL be 64-bit modulo 2^64, with wrap-around silently allowed.
REQ-021 The PC update latency SHALL be exactly one clock; PC4 SHALL always equal PC+4 in the same cycle.
REQ-022 When PC_FS=10 and in[1:0]!=00, align_fault SHALL be set on that edge.
REQ-023 align_fault SHALL remain set until reset, and SHALL NOT block PC updates.
REQ-024 status SHALL load status_in on an edge where status_load=1, and SHALL hold otherwise.
REQ-025 The status load SHALL be independent of PC_FS, so a status load and a PC update in the same cycle SHALL both take effect.
REQ-026 instr_cnt SHALL increment by 1 on every edge with PC_FS!=00.
REQ-027 taken_cnt SHALL increment by 1 on every edge with PC_FS=10, or with PC_FS=11 and k!=0.
REQ-028 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-029 No output SHALL depend combinationally on PC_FS, k, in or status_in, except PC4, which depends on PC.

Reset
REQ-030 When reset=0 at a rising edge, PC SHALL load RESET_PC, status 4'b0000, align_fault 0, instr_cnt 0 and taken_cnt 0.
REQ-031 Reset SHALL override all other inputs in the same cycle, including a PC_FS or status_load asserted mid-operation.
REQ-032 In the first cycle after reset is released, the module SHALL act on its inputs normally.

Verification
REQ-033 Reset release followed by 3 cycles of PC_FS=01 -> PC sequence 0, 4, 8, 12; instr_cnt=3; taken_cnt=0.
REQ-034 PC=0x100, PC_FS=11, k=-2 (all-ones...FE) -> PC=0xF8 next cycle; taken_cnt increments by 1.
REQ-035 PC_FS=10, in=0x2003 -> PC=0x2000 and align_fault=1; then PC_FS=01 -> PC=0x2004 with align_fault still 1.
REQ-036 status_load=1, status_in=4'b1010, PC_FS=00 -> status=1010 and PC held; next cycle with status_load=0 -> status still 1010.
REQ-037 With CNT_W=4 and 20 cycles of PC_FS=01 -> instr_cnt stays 4'hF; PC=0xFFFF_FFFF_FFFF_FFFC then PC_FS=01 -> PC=0.
REQ-038 Reset=0 asserted while PC_FS=11 and status_load=1 -> PC=RESET_PC, status=0 and all counters 0 on that edge.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit -- program counter with status-flag register and performance counters.
//
// Ports:
//   clock        single clock; all state changes on its rising edge
//   reset        synchronous, active-low
//   PC_FS[1:0]   PC function: 00 hold, 01 PC+4, 10 load {in[63:2],00}, 11 PC+(k<<2)
//   k[63:0]      sign-extended branch offset in instruction words
//   in[63:0]     register-sourced branch target
//   status_in    {V,C,N,Z} from the ALU
//   status_load  latch status_in this edge
//   PC[63:0]     current program counter (registered)
//   PC4[63:0]    PC+4, combinational from PC only
//   status[3:0]  registered {V,C,N,Z}
//   align_fault  sticky; set by a load-in target with in[1:0] != 00
//   instr_cnt    saturating count of edges with PC_FS != 00
//   taken_cnt    saturating count of load-ins and non-zero-offset jumps
module pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       PC_FS,
    input  logic [63:0]      k,
    input  logic [63:0]      in,
    input  logic [3:0]       status_in,
    input  logic             status_load,
    output logic [63:0]      PC,
    output logic [63:0]      PC4,
    output logic [3:0]       status,
    output logic             align_fault,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    logic [63:0] next_pc;
    logic        advance;
    logic        taken;
    logic        misaligned;

    assign PC4 = PC + 64'd4;

    always_comb begin
        next_pc    = PC;
        advance    = 1'b0;
        taken      = 1'b0;
        misaligned = 1'b0;
        unique case (PC_FS)
            2'b00: begin
                next_pc = PC;
            end
            2'b01: begin
                next_pc = PC4;
                advance = 1'b1;
            end
            2'b10: begin
                next_pc    = {in[63:2], 2'b00};
                advance    = 1'b1;
                taken      = 1'b1;
                misaligned = (in[1:0] != 2'b00);
            end
            2'b11: begin
                // Offset is in words; the shift drops k[63:62], which is
                // harmless under modulo-2^64 arithmetic.
                next_pc = PC + {k[61:0], 2'b00};
                advance = 1'b1;
                taken   = (k != '0);
            end
            default: begin
                next_pc = PC;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            PC          <= RESET_PC;
            status      <= '0;
            align_fault <= 1'b0;
            instr_cnt   <= '0;
            taken_cnt   <= '0;
        end else begin
            PC <= next_pc;
            if (status_load) begin
                status <= status_in;
            end
            if (misaligned) begin
                align_fault <= 1'b1;
            end
            if (advance && (instr_cnt != '1)) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
            if (taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  PC_FS;
    logic [63:0] k;
    logic [63:0] in;
    logic [3:0]  status_in;
    logic        status_load;

    logic [63:0] pc_a, pc4_a, pc_b, pc4_b;
    logic [3:0]  status_a, status_b;
    logic        af_a, af_b;
    logic [31:0] icnt_a, tcnt_a;
    logic [3:0]  icnt_b, tcnt_b;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clock = ~clock;

    pc_unit dut_a (
        .clock      (clock),
        .reset      (reset),
        .PC_FS      (PC_FS),
        .k          (k),
        .in         (in),
        .status_in  (status_in),
        .status_load(status_load),
        .PC         (pc_a),
        .PC4        (pc4_a),
        .status     (status_a),
        .align_fault(af_a),
        .instr_cnt  (icnt_a),
        .taken_cnt  (tcnt_a)
    );

    pc_unit #(.RESET_PC(64'h0), .CNT_W(4)) dut_b (
        .clock      (clock),
        .reset      (reset),
        .PC_FS      (PC_FS),
        .k          (k),
        .in         (in),
        .status_in  (status_in),
        .status_load(status_load),
        .PC         (pc_b),
        .PC4        (pc4_b),
        .status     (status_b),
        .align_fault(af_b),
        .instr_cnt  (icnt_b),
        .taken_cnt  (tcnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic [1:0] fs, input logic [63:0] kv,
                        input logic [63:0] iv, input logic sl, input logic [3:0] si);
        reset       = rst;
        PC_FS       = fs;
        k           = kv;
        in          = iv;
        status_load = sl;
        status_in   = si;
        @(posedge clock);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [63:0] exp);
        check({tag, ".pc"},  pc_a,  exp);
        check({tag, ".pc4"}, pc4_a, exp + 64'd4);
    endtask

    initial begin
        reset = 1'b0; PC_FS = 2'b00; k = '0; in = '0; status_load = 1'b0; status_in = '0;
        #1;

        // Reset state
        step(1'b0, 2'b00, '0, '0, 1'b0, 4'h0);
        check_pc("rst", 64'h0);
        check("rst.status", status_a, 4'h0);
        check("rst.af",     af_a,     1'b0);
        check("rst.icnt",   icnt_a,   0);
        check("rst.tcnt",   tcnt_a,   0);

        // Three sequential advances
        step(1'b1, 2'b01, '0, '0, 1'b0, 4'h0);
        check_pc("seq1", 64'h4);
        step(1'b1, 2'b01, '0, '0, 1'b0, 4'h0);
        check_pc("seq2", 64'h8);
        step(1'b1, 2'b01, '0, '0, 1'b0, 4'h0);
        check_pc("seq3", 64'hC);
        check("seq.icnt", icnt_a, 3);
        check("seq.tcnt", tcnt_a, 0);

        // Aligned load-in, then backward jump k=-2
        step(1'b1, 2'b10, '0, 64'h100, 1'b0, 4'h0);
        check_pc("ld100", 64'h100);
        check("ld100.af",   af_a,   1'b0);
        check("ld100.tcnt", tcnt_a, 1);
        step(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, '0, 1'b0, 4'h0);
        check_pc("jmpm2", 64'hF8);
        check("jmpm2.tcnt", tcnt_a, 2);
        check("jmpm2.icnt", icnt_a, 5);

        // Jump with k=0: counts as advance, not taken
        step(1'b1, 2'b11, '0, '0, 1'b0, 4'h0);
        check_pc("jmp0", 64'hF8);
        check("jmp0.tcnt", tcnt_a, 2);
        check("jmp0.icnt", icnt_a, 6);

        // Hold
        step(1'b1, 2'b00, 64'h5, 64'h777, 1'b0, 4'h0);
        check_pc("hold", 64'hF8);
        check("hold.icnt", icnt_a, 6);

        // Misaligned load-in sets sticky fault; does not block updates
        step(1'b1, 2'b10, '0, 64'h2003, 1'b0, 4'h0);
        check_pc("mis", 64'h2000);
        check("mis.af",   af_a,   1'b1);
        check("mis.tcnt", tcnt_a, 3);
        step(1'b1, 2'b01, '0, '0, 1'b0, 4'h0);
        check_pc("mis.next", 64'h2004);
        check("mis.next.af", af_a, 1'b1);
        check("mis.icnt",    icnt_a, 8);

        // Status register load and hold
        step(1'b1, 2'b00, '0, '0, 1'b1, 4'b1010);
        check("st.load", status_a, 4'b1010);
        check_pc("st.load", 64'h2004);
        step(1'b1, 2'b00, '0, '0, 1'b0, 4'b0101);
        check("st.hold", status_a, 4'b1010);
        step(1'b1, 2'b01, '0, '0, 1'b1, 4'b0011);
        check("st.both", status_a, 4'b0011);
        check_pc("st.both", 64'h2008);
        check("st.icnt", icnt_a, 9);

        // Narrow counters saturate
        for (int i = 0; i < 20; i++) step(1'b1, 2'b01, '0, '0, 1'b0, 4'h0);
        check_pc("sat.i", 64'h2058);
        check("sat.icnt_b", icnt_b, 4'hF);
        check("sat.icnt_a", icnt_a, 29);
        check("sat.tcnt_b", tcnt_b, 4'h3);
        for (int i = 0; i < 15; i++) step(1'b1, 2'b11, 64'h1, '0, 1'b0, 4'h0);
        check_pc("sat.t", 64'h2094);
        check("sat.tcnt_b", tcnt_b, 4'hF);
        check("sat.tcnt_a", tcnt_a, 18);
        check("sat.icnt_b2", icnt_b, 4'hF);

        // 64-bit wrap
        step(1'b1, 2'b10, '0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 4'h0);
        check("wrap.pc",  pc_a,  64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap.pc4", pc4_a, 64'h0);
        step(1'b1, 2'b01, '0, '0, 1'b0, 4'h0);
        check_pc("wrap.inc", 64'h0);
        step(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, '0, 1'b0, 4'h0);
        check_pc("wrap.jmp", 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap.af", af_a, 1'b1);

        // Reset overrides jump and status load
        step(1'b0, 2'b11, 64'h10, 64'h3, 1'b1, 4'hF);
        check_pc("rst2", 64'h0);
        check("rst2.status", status_a, 4'h0);
        check("rst2.af",     af_a,     1'b0);
        check("rst2.icnt",   icnt_a,   0);
        check("rst2.tcnt",   tcnt_a,   0);
        check("rst2.icnt_b", icnt_b,   0);
        check("rst2.tcnt_b", tcnt_b,   0);
        check("rst2.pc_b",   pc_b,     64'h0);

        // First cycle after release acts normally
        step(1'b1, 2'b01, '0, '0, 1'b1, 4'b0110);
        check_pc("post", 64'h4);
        check("post.icnt",   icnt_a,   1);
        check("post.status", status_a, 4'b0110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
